// File: rtl/serial_bus_loader_pkg.sv
// rtl/serial_bus_loader_pkg.sv - opcodes, state encodings and helpers shared by the serial bus loader
package serial_bus_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_REQ,
    ST_BUS,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT,
    TX_START,
    TX_GUARD
  } tx_state_t;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/serial_bus_loader_if.sv
// rtl/serial_bus_loader_if.sv - device-bus initiator signals (ownership handshake plus word transaction)
interface serial_bus_loader_if;
  logic        busReq_o;
  logic        busGrant_i;
  logic        devEnable_o;
  logic        devWrite_o;
  logic        devBusy_i;
  logic [31:0] devPhysicalAddr_o;
  logic [31:0] devDataSave_o;
  logic [31:0] devDataLoad_i;
  logic [3:0]  devByteSelect_o;

  modport master (
    output busReq_o, devEnable_o, devWrite_o, devPhysicalAddr_o, devDataSave_o, devByteSelect_o,
    input  busGrant_i, devBusy_i, devDataLoad_i
  );

  modport slave (
    input  busReq_o, devEnable_o, devWrite_o, devPhysicalAddr_o, devDataSave_o, devByteSelect_o,
    output busGrant_i, devBusy_i, devDataLoad_i
  );
endinterface

// File: rtl/serial_bus_loader_tx_seq.sv
// rtl/serial_bus_loader_tx_seq.sv - paces 1..4 reply bytes (LSB first) into the UART transmitter
module serial_tx_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  count_i,
  input  logic [31:0] payload_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o,
  output logic        done_o
);
  import serial_bus_loader_pkg::*;

  tx_state_t   state_q, state_d;
  logic [2:0]  left_q, left_d;
  logic [31:0] shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      left_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      shift_q <= shift_d;
    end
  end

  // The guard state keeps txdBusy_i unsampled for one cycle after each start pulse.
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    shift_d = shift_q;
    done_o  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start_i) begin
          left_d  = count_i;
          shift_d = payload_i;
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!txdBusy_i) state_d = TX_START;
      end
      TX_START: begin
        shift_d = {8'h00, shift_q[31:8]};
        left_d  = left_q - 3'd1;
        state_d = TX_GUARD;
      end
      TX_GUARD: begin
        if (left_q == 3'd0) begin
          done_o  = 1'b1;
          state_d = TX_IDLE;
        end else begin
          state_d = TX_WAIT;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign txdStart_o = (state_q == TX_START);
  assign txdData_o  = (state_q == TX_START) ? shift_q[7:0] : 8'h00;

endmodule

// File: rtl/serial_bus_loader.sv
// rtl/serial_bus_loader.sv - serial-port debug bus initiator; SERIAL_LOADER_TIMEOUT_EN adds an inter-byte timeout
module serial_bus_loader #(
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxdReady_i,
  input  logic [7:0] rxdData_i,
  input  logic       txdBusy_i,
  output logic       txdStart_o,
  output logic [7:0] txdData_o,
  serial_bus_loader_if.master dev,
  output logic       overrun_o
);
  import serial_bus_loader_pkg::*;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        overrun_q, overrun_d;

  logic        tx_start;
  logic [2:0]  tx_count;
  logic [31:0] tx_payload;
  logic        tx_done;
  logic        timeout;

`ifdef SERIAL_LOADER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] gap_q, gap_d;
  logic             collecting;

  assign collecting = (state_q == ST_ADDR) || (state_q == ST_DATA);

  always_comb begin
    gap_d = '0;
    if (collecting && !rxdReady_i) gap_d = gap_q + TMR_W'(1);
  end

  assign timeout = collecting && !rxdReady_i && (gap_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) gap_q <= '0;
    else     gap_q <= gap_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    overrun_d  = overrun_q;
    tx_start   = 1'b0;
    tx_count   = 3'd1;
    tx_payload = {24'h0, RSP_NAK};

    if (rxdReady_i && (state_q == ST_REQ || state_q == ST_BUS || state_q == ST_RESP))
      overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rxdReady_i) begin
          opcode_d = rxdData_i;
          cnt_d    = 2'd0;
          if (rxdData_i == CMD_WRITE || rxdData_i == CMD_READ) begin
            state_d = ST_ADDR;
          end else begin
            tx_start = 1'b1;
            state_d  = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (rxdReady_i) begin
          addr_d[{cnt_q, 3'b000} +: 8] = rxdData_i;
          cnt_d = cnt_q + 2'd1;
          // addr_q[1:0] is already final here: byte 0 arrived first.
          if (cnt_q == 2'd3) begin
            if (opcode_q == CMD_WRITE) begin
              state_d = ST_DATA;
            end else if (!word_aligned(addr_q)) begin
              tx_start = 1'b1;
              state_d  = ST_RESP;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_DATA: begin
        if (rxdReady_i) begin
          data_d[{cnt_q, 3'b000} +: 8] = rxdData_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (!word_aligned(addr_q)) begin
              tx_start = 1'b1;
              state_d  = ST_RESP;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_REQ: begin
        if (dev.busGrant_i) state_d = ST_BUS;
      end
      ST_BUS: begin
        // Read data goes straight into the reply sequencer on the completing edge.
        if (!dev.devBusy_i) begin
          tx_start = 1'b1;
          state_d  = ST_RESP;
          if (opcode_q == CMD_WRITE) begin
            tx_payload = {24'h0, RSP_ACK};
          end else begin
            tx_count   = 3'd4;
            tx_payload = dev.devDataLoad_i;
          end
        end
      end
      ST_RESP: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) state_d = ST_IDLE;
  end

  serial_tx_seq u_tx_seq (
    .clk        (clk),
    .rst        (rst),
    .start_i    (tx_start),
    .count_i    (tx_count),
    .payload_i  (tx_payload),
    .txdBusy_i  (txdBusy_i),
    .txdStart_o (txdStart_o),
    .txdData_o  (txdData_o),
    .done_o     (tx_done)
  );

  assign dev.busReq_o          = (state_q == ST_REQ) || (state_q == ST_BUS);
  assign dev.devEnable_o       = (state_q == ST_BUS);
  assign dev.devWrite_o        = (state_q == ST_BUS) && (opcode_q == CMD_WRITE);
  assign dev.devByteSelect_o   = (state_q == ST_BUS) ? 4'hf : 4'h0;
  assign dev.devPhysicalAddr_o = addr_q;
  assign dev.devDataSave_o     = data_q;
  assign overrun_o             = overrun_q;

endmodule

// File: tb/tb_serial_bus_loader.sv
// tb/tb_serial_bus_loader.sv - directed self-checking bench for serial_bus_loader
module tb_serial_bus_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxdReady_i = 1'b0;
  logic [7:0] rxdData_i = 8'h00;
  logic       txdBusy_i = 1'b0;
  logic       txdStart_o;
  logic [7:0] txdData_o;
  logic       overrun_o;

  serial_bus_loader_if dev_bus();

  serial_bus_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxdReady_i (rxdReady_i),
    .rxdData_i  (rxdData_i),
    .txdBusy_i  (txdBusy_i),
    .txdStart_o (txdStart_o),
    .txdData_o  (txdData_o),
    .dev        (dev_bus),
    .overrun_o  (overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } txn_t;

  int          total = 0;
  int          bad = 0;
  txn_t        exp_txn[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  frame_q[$];
  int          grant_delay = 0;
  int          busy_cycles = 0;
  logic [31:0] load_word = 32'h0;
  int          req_cnt = 0;
  int          en_cnt = 0;
  int          uart_cnt = 0;
  int          last_en_cycles = 0;
  logic        seen_req = 1'b0;
  logic        seen_en = 1'b0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_data = 32'h0;
  logic        last_wr = 1'b0;
  logic [3:0]  last_bsel = 4'h0;
  txn_t        mon_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, want);
    end
  endtask

  // Device, arbiter and UART models plus per-cycle compare, all on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      en_cnt = 0; req_cnt = 0; uart_cnt = 0;
      dev_bus.busGrant_i = 1'b0; dev_bus.devBusy_i = 1'b0; txdBusy_i = 1'b0;
    end else begin
      if (dev_bus.devEnable_o) begin
        chk("en_implies_req", 32'(dev_bus.busReq_o), 32'd1);
        chk("en_implies_grant", 32'(dev_bus.busGrant_i), 32'd1);
      end
      chk("byte_select", 32'(dev_bus.devByteSelect_o), dev_bus.devEnable_o ? 32'hf : 32'h0);
      if (dev_bus.busReq_o) seen_req = 1'b1;
      if (dev_bus.devEnable_o) seen_en = 1'b1;
      if (txdStart_o) begin
        chk("tx_while_busy", 32'(txdBusy_i), 32'd0);
        tx_log.push_back(txdData_o);
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: got=%h want=none", txdData_o);
        end else begin
          chk("tx_byte", 32'(txdData_o), 32'(exp_tx.pop_front()));
        end
      end
      if (dev_bus.devEnable_o) begin
        en_cnt++;
        dev_bus.devBusy_i = (en_cnt <= busy_cycles);
        if (!dev_bus.devBusy_i) begin
          last_en_cycles = en_cnt;
          last_addr = dev_bus.devPhysicalAddr_o;
          last_data = dev_bus.devDataSave_o;
          last_wr   = dev_bus.devWrite_o;
          last_bsel = dev_bus.devByteSelect_o;
          if (exp_txn.size() == 0) begin
            total++; bad++;
            $display("FAIL bus_unexpected: got addr=%h want=none", dev_bus.devPhysicalAddr_o);
          end else begin
            mon_t = exp_txn.pop_front();
            chk("bus_addr", dev_bus.devPhysicalAddr_o, mon_t.addr);
            chk("bus_write", 32'(dev_bus.devWrite_o), 32'(mon_t.wr));
            if (mon_t.wr) chk("bus_data", dev_bus.devDataSave_o, mon_t.data);
          end
        end
      end else begin
        en_cnt = 0;
        dev_bus.devBusy_i = 1'b0;
      end
      if (dev_bus.busReq_o) begin
        req_cnt++;
        dev_bus.busGrant_i = (req_cnt > grant_delay);
      end else begin
        req_cnt = 0;
        dev_bus.busGrant_i = 1'b0;
      end
      if (txdStart_o) uart_cnt = 5;
      txdBusy_i = (uart_cnt > 0);
      if (uart_cnt > 0) uart_cnt--;
    end
  end

  // Reference model: what a complete frame must produce on the bus and on the serial line.
  task automatic expect_frame();
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    txn_t        t;
    op = frame_q[0];
    if (op != 8'h57 && op != 8'h52) begin
      exp_tx.push_back(8'h15);
      return;
    end
    a = 32'h0;
    d = 32'h0;
    for (int i = 0; i < 4; i++) a = a | ({24'h0, frame_q[1+i]} << (8 * i));
    if (op == 8'h57)
      for (int i = 0; i < 4; i++) d = d | ({24'h0, frame_q[5+i]} << (8 * i));
    if (a % 4 != 0) begin
      exp_tx.push_back(8'h15);
      return;
    end
    t.addr = a; t.data = d; t.wr = (op == 8'h57);
    exp_txn.push_back(t);
    if (t.wr) exp_tx.push_back(8'h06);
    else for (int i = 0; i < 4; i++) exp_tx.push_back(8'((load_word >> (8 * i)) & 32'hff));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxdData_i = b;
    rxdReady_i = 1'b1;
    @(negedge clk);
    rxdReady_i = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_txn.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL wait_done: got pending_tx=%0d pending_bus=%0d want=0", exp_tx.size(), exp_txn.size());
      exp_tx.delete();
      exp_txn.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame();
    seen_req = 1'b0;
    seen_en = 1'b0;
    tx_log.delete();
    expect_frame();
    send_frame();
    wait_done();
  endtask

  task automatic set_load(input logic [31:0] w);
    load_word = w;
    dev_bus.devDataLoad_i = w;
  endtask

  initial begin
    int n;
    dev_bus.busGrant_i = 1'b0;
    dev_bus.devBusy_i = 1'b0;
    set_load(32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busReq", 32'(dev_bus.busReq_o), 32'd0);
    chk("rst_devEnable", 32'(dev_bus.devEnable_o), 32'd0);
    chk("rst_devWrite", 32'(dev_bus.devWrite_o), 32'd0);
    chk("rst_addr", dev_bus.devPhysicalAddr_o, 32'd0);
    chk("rst_bsel", 32'(dev_bus.devByteSelect_o), 32'd0);
    chk("rst_txdStart", 32'(txdStart_o), 32'd0);
    chk("rst_txdData", 32'(txdData_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    rst = 1'b0;

    // Aligned write, immediate grant and ready.
    frame_q = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame();
    chk("w_addr", last_addr, 32'h80000000);
    chk("w_data", last_data, 32'hDEADBEEF);
    chk("w_wr", 32'(last_wr), 32'd1);
    chk("w_bsel", 32'(last_bsel), 32'hf);
    chk("w_en_cycles", 32'(last_en_cycles), 32'd1);
    chk("w_tx_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) chk("w_tx_ack", 32'(tx_log[0]), 32'h06);

    // Read with three busy cycles.
    busy_cycles = 3;
    set_load(32'h12345678);
    frame_q = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h80};
    run_frame();
    chk("r_addr", last_addr, 32'h80000004);
    chk("r_wr", 32'(last_wr), 32'd0);
    chk("r_en_cycles", 32'(last_en_cycles), 32'd4);
    chk("r_tx_count", 32'(tx_log.size()), 32'd4);
    if (tx_log.size() == 4) begin
      chk("r_tx0", 32'(tx_log[0]), 32'h78);
      chk("r_tx1", 32'(tx_log[1]), 32'h56);
      chk("r_tx2", 32'(tx_log[2]), 32'h34);
      chk("r_tx3", 32'(tx_log[3]), 32'h12);
    end

    // Unknown opcode.
    busy_cycles = 0;
    frame_q = '{8'h41};
    run_frame();
    chk("bad_tx_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) chk("bad_tx_nak", 32'(tx_log[0]), 32'h15);
    chk("bad_no_req", 32'(seen_req), 32'd0);

    // Unaligned write address.
    frame_q = '{8'h57, 8'h02, 8'h00, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame();
    chk("unal_tx_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) chk("unal_tx_nak", 32'(tx_log[0]), 32'h15);
    chk("unal_no_en", 32'(seen_en), 32'd0);
    chk("unal_no_req", 32'(seen_req), 32'd0);

    // Delayed grant with a byte injected while requesting.
    grant_delay = 10;
    seen_req = 1'b0;
    seen_en = 1'b0;
    tx_log.delete();
    frame_q = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    expect_frame();
    send_frame();
    n = 0;
    while (!dev_bus.busReq_o && n < 50) begin @(negedge clk); n++; end
    chk("gd_req_seen", 32'(dev_bus.busReq_o), 32'd1);
    send_byte(8'h33);
    chk("gd_en_low", 32'(dev_bus.devEnable_o), 32'd0);
    chk("gd_overrun", 32'(overrun_o), 32'd1);
    wait_done();
    chk("gd_addr", last_addr, 32'h00000010);
    chk("gd_data", last_data, 32'hCAFEF00D);
    chk("gd_overrun_sticky", 32'(overrun_o), 32'd1);
    if (tx_log.size() == 1) chk("gd_tx_ack", 32'(tx_log[0]), 32'h06);
    else chk("gd_tx_count", 32'(tx_log.size()), 32'd1);

    // Reset while the bus transaction is held busy.
    grant_delay = 0;
    busy_cycles = 50;
    tx_log.delete();
    frame_q = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h80};
    send_frame();
    n = 0;
    while (!dev_bus.devEnable_o && n < 50) begin @(negedge clk); n++; end
    chk("rb_in_bus", 32'(dev_bus.devEnable_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rb_devEnable", 32'(dev_bus.devEnable_o), 32'd0);
    chk("rb_busReq", 32'(dev_bus.busReq_o), 32'd0);
    chk("rb_txdStart", 32'(txdStart_o), 32'd0);
    chk("rb_overrun", 32'(overrun_o), 32'd0);
    repeat (20) @(negedge clk);
    chk("rb_no_reply", 32'(tx_log.size()), 32'd0);
    busy_cycles = 0;
    set_load(32'hA5A50F0F);
    frame_q = '{8'h52, 8'h0C, 8'h00, 8'h00, 8'h80};
    run_frame();
    chk("rb2_addr", last_addr, 32'h8000000C);
    if (tx_log.size() == 4) begin
      chk("rb2_tx0", 32'(tx_log[0]), 32'h0F);
      chk("rb2_tx3", 32'(tx_log[3]), 32'hA5);
    end else begin
      chk("rb2_tx_count", 32'(tx_log.size()), 32'd4);
    end

`ifdef SERIAL_LOADER_TIMEOUT_EN
    // Partial frame abandoned by the inter-byte timeout.
    tx_log.delete();
    send_byte(8'h52);
    send_byte(8'h04);
    repeat (105) @(negedge clk);
    chk("to_no_reply", 32'(tx_log.size()), 32'd0);
    chk("to_no_req", 32'(dev_bus.busReq_o), 32'd0);
    set_load(32'h0BADF00D);
    frame_q = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h80};
    run_frame();
    chk("to_addr", last_addr, 32'h80000000);
    if (tx_log.size() == 4) chk("to_tx0", 32'(tx_log[0]), 32'h0D);
    else chk("to_tx_count", 32'(tx_log.size()), 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
